// File: rtl/serial_to_parallel_stream_pkg.sv
// Shared types and helpers for the serial-to-parallel deserializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_to_parallel_stream_pkg;

    // Beat placement order within an assembled word.
    typedef enum logic {
        LSB_FIRST = 1'b0,
        MSB_FIRST = 1'b1
    } beat_order_t;

    // Number of serial beats that make up one output word.
    function automatic int beats_per_word(input int width, input int lanes);
        return width / lanes;
    endfunction

endpackage

// File: rtl/serial_to_parallel_stream_if.sv
// Stream bundle: lanes-wide serial input side and width-wide parallel output side.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both sides.
// Ports: slave = deserializer view, master = source/sink view.
interface serial_to_parallel_stream_if #(
    parameter int width = 8,
    parameter int lanes = 1
);
    logic             serial_valid;
    logic [lanes-1:0] serial_data;
    logic             serial_ready;
    logic             parallel_valid;
    logic [width-1:0] parallel_data;
    logic             parallel_ready;

    modport slave (
        input  serial_valid,
        input  serial_data,
        output serial_ready,
        output parallel_valid,
        output parallel_data,
        input  parallel_ready
    );

    modport master (
        output serial_valid,
        output serial_data,
        input  serial_ready,
        input  parallel_valid,
        input  parallel_data,
        output parallel_ready
    );
endinterface

// File: rtl/s2p_hold_reg.sv
// Single-entry output holding register for assembled words.
// Latency: word visible the cycle after load_i.
// Backpressure: holds data stable while full_o && !drain_i; load wins over drain.
// Ports: clk, rst_n, load_i/data_i (new word), drain_i (consumer ready), full_o/data_o.
module s2p_hold_reg #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [width-1:0] data_i,
    input  logic             drain_i,
    output logic             full_o,
    output logic [width-1:0] data_o
);
    logic             full_q, full_d;
    logic [width-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (load_i) begin
            // A load in the same cycle as a drain replaces the word with no bubble.
            full_d = 1'b1;
            data_d = data_i;
        end else if (full_q && drain_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;
endmodule

// File: rtl/serial_to_parallel_stream.sv
// Multi-lane serial-to-parallel deserializer, LSB- or MSB-first beat order, with flush.
// Latency: parallel_valid rises on the edge accepting the final beat of a word.
// Backpressure: only the final beat stalls (serial_ready low) while the held word is not taken.
// Ports: clk, rst_n, flush, msb_first, bus (slave modport: serial in, parallel out).
module serial_to_parallel_stream
    import serial_to_parallel_stream_pkg::*;
#(
    parameter int width = 8,
    parameter int lanes = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           msb_first,
    serial_to_parallel_stream_if.slave     bus
);
    localparam int N  = beats_per_word(width, lanes);
    localparam int CW = $clog2(N);

    if (width % lanes != 0) begin : g_chk_div
        $error("serial_to_parallel_stream: width must be a multiple of lanes");
    end
    if (N < 2) begin : g_chk_beats
        $error("serial_to_parallel_stream: width/lanes must be at least 2");
    end

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [width-1:0] acc_q, acc_d;
    beat_order_t      order_q, order_d;

    logic             full;
    logic             last_beat;
    logic             beat_acc;
    logic             load;
    beat_order_t      order_eff;
    logic [CW-1:0]    slot;
    logic [width-1:0] asm_word;

    assign last_beat = (cnt_q == CW'(N - 1));

    // Final beat may enter in the cycle the held word drains (combinational from ready).
    assign bus.serial_ready = rst_n && !flush && (!last_beat || !full || bus.parallel_ready);
    assign beat_acc         = bus.serial_valid && bus.serial_ready;
    assign load             = beat_acc && last_beat;

    always_comb begin
        // Order is taken live on the first beat and from the latch afterwards.
        order_eff = order_q;
        if (cnt_q == '0) begin
            order_eff = msb_first ? MSB_FIRST : LSB_FIRST;
        end
        slot = (order_eff == MSB_FIRST) ? (CW'(N - 1) - cnt_q) : cnt_q;
        // Unfilled slots in the accumulator are always zero, so OR-in is enough.
        asm_word = acc_q | (width'(bus.serial_data) << (int'(slot) * lanes));
    end

    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        order_d = order_q;
        if (flush) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (beat_acc) begin
            if (cnt_q == '0) begin
                order_d = order_eff;
            end
            if (last_beat) begin
                cnt_d = '0;
                acc_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
                acc_d = asm_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            order_q <= LSB_FIRST;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            order_q <= order_d;
        end
    end

    s2p_hold_reg #(.width(width)) u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .data_i  (asm_word),
        .drain_i (bus.parallel_ready),
        .full_o  (full),
        .data_o  (bus.parallel_data)
    );

    assign bus.parallel_valid = full;
endmodule

// File: doc/serial_to_parallel_stream.md
# serial_to_parallel_stream

Multi-lane serial-to-parallel deserializer with a one-word output holding register and valid/ready backpressure on both sides. It accepts `lanes` bits per beat, assembles `width`-bit words in LSB-first or MSB-first beat order, and can discard a partial word with `flush`. It sits between a serial link front end and a word-oriented stream consumer that may stall.

## Interface

- `width`, default 8: output word width; must be a multiple of `lanes`.
- `lanes`, default 1: serial bits per beat; `width / lanes >= 2`.
- `clk` input 1: the only clock; all logic is on its rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `flush` input 1: discards the partial word in the accumulator.
- `msb_first` input 1: beat order; 0 = LSB-first, 1 = MSB-first.
- `serial_valid` input 1: serial beat present.
- `serial_data` input `lanes`: beat payload.
- `serial_ready` output 1: the beat is accepted when `serial_valid && serial_ready`.
- `parallel_valid` output 1: word present in the holding register.
- `parallel_data` output `width`: assembled word.
- `parallel_ready` input 1: the consumer takes the word when `parallel_valid && parallel_ready`.

## Operation

- Constant `N = width / lanes`.
- Beat counter `cnt` runs 0..N-1. Accumulator holds the beats received so far.
- Beat placement for beat k:
  - LSB-first: bits `[k*lanes +: lanes]`.
  - MSB-first: bits `[width-1-k*lanes -: lanes]`.
  - The order of bits inside a beat is preserved as given.
- Beat-order latching:
  - `msb_first` is sampled on the accepted beat with `cnt == 0`.
  - The sampled value is held for the rest of the word.
  - Changes on `msb_first` mid-word are ignored.
- `serial_ready = rst_n && !flush && (cnt != N-1 || !parallel_valid || parallel_ready)`.
  - This is a combinational path from `parallel_ready`.
  - Non-final beats are never stalled.
- Accepted beat with `cnt < N-1`: store the beat and increment `cnt`.
- Accepted beat with `cnt == N-1`:
  - Load the assembled word, including this beat, into `parallel_data`.
  - Set `parallel_valid` and reset `cnt` to 0.
- Output drain: on `parallel_valid && parallel_ready` with no completing beat in the same cycle, clear `parallel_valid`.
- Simultaneous drain and completion: the new word is loaded and `parallel_valid` stays 1. There is no bubble.
- `flush`:
  - Clears `cnt` and the accumulator.
  - No beat is accepted that cycle.
  - The holding register and `parallel_valid` are unaffected.
- Stall hold: while `parallel_valid && !parallel_ready`, `parallel_data` is held stable.
- Reset:
  - Applies on a `clk` edge with `rst_n == 0`.
  - `parallel_valid` = 0, `parallel_data` = 0, `cnt` = 0, accumulator = 0, latched order = LSB-first.
  - `serial_ready` = 0 while `rst_n` is low.
  - Reset mid-word discards the partial word and any held word.
- `serial_data` is don't-care when `serial_valid` is 0.

## Timing

- Latency: `parallel_valid` rises on the edge that accepts the final beat, i.e. one cycle after the final beat is presented.
- Throughput: with `parallel_ready` held at 1, one beat per cycle sustained, giving one word per N cycles.
- Backpressure: a final beat waits with `serial_ready` = 0 until the held word drains. It may be accepted in the same cycle the held word drains.
- Parallel-side valid/ready rules:
  - Once asserted, `parallel_valid` stays high until the word is taken.
  - `parallel_valid` does not depend combinationally on `parallel_ready`.
- Serial-side behaviour: a beat held with `serial_valid` = 1 while `serial_ready` = 0 is not consumed.

## Structure

- Package `serial_to_parallel_stream_pkg`:
  - enum `beat_order_t` with values `LSB_FIRST` and `MSB_FIRST`.
  - function `beats_per_word(width, lanes)`.
- Elaboration-time checks: `width % lanes == 0` and `N >= 2`; elaboration fails otherwise.
- Top module: accumulator, `cnt` (width `$clog2(N)`), latched order.
- One sub-module, `s2p_hold_reg`:
  - Holds the single-entry output register with load/drain logic.
  - Parameterised by `width`.
  - Exposes `full` to the top for the `serial_ready` computation.

## Test plan

- LSB-first bits, `width`=8, `lanes`=1: bits 1,0,1,1,0,0,0,1 on consecutive cycles with `parallel_ready`=1 -> `parallel_valid` for one cycle with `parallel_data`=8'h8D, one cycle after the last bit.
- MSB-first bits, `width`=8, `lanes`=1: same bits with `msb_first`=1 -> 8'hB1. Toggling `msb_first` after the first bit still yields 8'hB1.
- Multi-lane, `width`=8, `lanes`=2: beats 2'b01, 2'b10, 2'b11, 2'b00 -> 8'h39 LSB-first and 8'h6C MSB-first.
- Backpressure, `lanes`=1: hold `parallel_ready`=0 and stream 16 bits.
  - The first word stays stable.
  - `serial_ready` drops only at beat 16.
  - Raising `parallel_ready` for 1 cycle drains word 1 and accepts bit 16 in that same cycle.
  - Word 2 appears with no gap.
- Flush: send 5 of 8 bits, pulse `flush` while `serial_valid`=1 -> that beat is not accepted. The next 8 bits form a clean word, with no residue from the first 5.
- Reset mid-word: after 3 bits and a held word, drive `rst_n`=0 for 1 cycle -> `parallel_valid`=0, `parallel_data`=0, `serial_ready`=0 during reset, and the next 8 bits produce a correct word.
